// File: rtl/iob_eth_rx_sched.sv
// rtl/iob_eth_rx_sched.sv - Ethernet RX double-buffer frame scheduler with CRC screening
module iob_eth_rx_sched #(
  parameter logic [31:0] CRC_RESIDUE = 32'hC704DD7B,
  parameter logic [10:0] MAX_NBYTES  = 11'd1500
) (
  input  logic        RX_CLK,
  input  logic        rst,
  input  logic        cfg_en,
  input  logic [10:0] cfg_nbytes,
  input  logic        rx_data_rcvd,
  input  logic [31:0] rx_crc_value,
  output logic        rx_rcv_ack,
  output logic [10:0] rx_nbytes,
  output logic        rx_buf_sel,
  output logic        rx_wr_en,
  output logic        frm_valid,
  output logic        frm_buf,
  output logic [10:0] frm_len,
  input  logic        frm_ready,
  output logic [15:0] drop_cnt,
  output logic [15:0] crc_err_cnt
);

  typedef enum logic [1:0] {IDLE, WAIT, CHECK, ACK} state_t;

  state_t           state;
  logic [1:0]       full;
  logic [1:0][10:0] len;
  logic             wp;
  logic             rp;
  logic [10:0]      nbytes_clamped;

  // Programmed payload size limited to what one buffer can hold
  assign nbytes_clamped = (cfg_nbytes > MAX_NBYTES) ? MAX_NBYTES : cfg_nbytes;

  // Host always sees the oldest buffer, straight from registers
  assign frm_valid = full[rp];
  assign frm_buf   = rp;
  assign frm_len   = len[rp];

  // Frame sequencing, buffer bookkeeping and drop statistics
  always_ff @(posedge RX_CLK or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      full        <= '0;
      len         <= '0;
      wp          <= 1'b0;
      rp          <= 1'b0;
      rx_rcv_ack  <= 1'b0;
      rx_nbytes   <= '0;
      rx_buf_sel  <= 1'b0;
      rx_wr_en    <= 1'b0;
      drop_cnt    <= '0;
      crc_err_cnt <= '0;
    end else begin
      // Host release; a fill later in this block targets wp, which never
      // equals a full rp while a write is enabled, so both updates land
      if (full[rp] && frm_ready) begin
        full[rp] <= 1'b0;
        rp       <= ~rp;
      end

      case (state)
        IDLE: begin
          rx_rcv_ack <= 1'b0;
          if (cfg_en) begin
            rx_nbytes  <= nbytes_clamped;
            rx_buf_sel <= wp;
            rx_wr_en   <= ~full[wp];
            state      <= WAIT;
          end
        end

        WAIT: begin
          if (rx_data_rcvd) state <= CHECK;
        end

        CHECK: begin
          // Write gate was fixed at frame start; a closed gate means no slot
          if (!rx_wr_en) begin
            if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
          end else if (rx_crc_value == CRC_RESIDUE) begin
            full[wp] <= 1'b1;
            len[wp]  <= rx_nbytes;
            wp       <= ~wp;
          end else begin
            if (crc_err_cnt != 16'hFFFF) crc_err_cnt <= crc_err_cnt + 16'd1;
          end
          rx_rcv_ack <= 1'b1;
          state      <= ACK;
        end

        ACK: begin
          // Hold the acknowledge until the receiver drops its complete level
          if (!rx_data_rcvd) begin
            rx_rcv_ack <= 1'b0;
            if (cfg_en) begin
              rx_nbytes  <= nbytes_clamped;
              rx_buf_sel <= wp;
              rx_wr_en   <= ~full[wp];
              state      <= WAIT;
            end else begin
              state <= IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/iob_eth_rx_sched.md
IOB_ETH_RX_SCHED -- requirements
Module: iob_eth_rx_sched

Interface
REQ-001 SHALL have parameter CRC_RESIDUE, default 32'hC704DD7B, meaning the good-frame CRC register value after FCS.
REQ-002 SHALL have parameter MAX_NBYTES, default 11'd1500, meaning the upper clamp on programmed payload size.
REQ-003 SHALL have port RX_CLK  input  1  receive clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port cfg_en  input  1  scheduler enable.
REQ-006 SHALL have port cfg_nbytes  input  11  payload bytes per frame.
REQ-007 SHALL have port rx_data_rcvd  input  1  receiver frame-complete level, held until acknowledged.
REQ-008 SHALL have port rx_crc_value  input  32  receiver CRC register, valid while rx_data_rcvd=1.
REQ-009 SHALL have port rx_rcv_ack  output  1  frame acknowledge to receiver.
REQ-010 SHALL have port rx_nbytes  output  11  payload size driven to receiver.
REQ-011 SHALL have port rx_buf_sel  output  1  buffer index the receiver writes.
REQ-012 SHALL have port rx_wr_en  output  1  buffer write gate; 0 = discard writes.
REQ-013 SHALL have port frm_valid  output  1  a good frame is waiting for the host.
REQ-014 SHALL have port frm_buf  output  1  buffer index of the waiting frame.
REQ-015 SHALL have port frm_len  output  11  payload size of the waiting frame.
REQ-016 SHALL have port frm_ready  input  1  host releases the waiting frame.
REQ-017 SHALL have port drop_cnt  output  16  frames dropped for lack of a buffer.
REQ-018 SHALL have port crc_err_cnt  output  16  frames dropped for bad CRC.

Function
REQ-019 SHALL use FSM states IDLE, WAIT, CHECK, ACK, plus two buffer slots with full[1:0], len[1:0][10:0], write pointer wp and read pointer rp.
REQ-020 IDLE: rx_rcv_ack=0; when cfg_en=1, SHALL latch rx_nbytes=min(cfg_nbytes,MAX_NBYTES), rx_buf_sel=wp, rx_wr_en=~full[wp], then go to WAIT.
REQ-021 rx_nbytes, rx_buf_sel and rx_wr_en SHALL stay constant from WAIT entry until ACK exit; a mid-frame host release SHALL NOT change rx_wr_en.
REQ-022 WAIT: when rx_data_rcvd=1, SHALL go to CHECK on the next edge.
REQ-023 CHECK (1 cycle): when rx_crc_value==CRC_RESIDUE and rx_wr_en=1, SHALL set full[wp]=1, len[wp]=rx_nbytes and toggle wp.
REQ-024 CHECK: when rx_wr_en=0, SHALL increment drop_cnt and leave the buffers unchanged, whatever the CRC.
REQ-025 CHECK: when rx_wr_en=1 and the CRC mismatches, SHALL increment crc_err_cnt and leave the buffers unchanged.
REQ-026 CHECK SHALL always go to ACK.
REQ-027 ACK: rx_rcv_ack=1 SHALL be held until rx_data_rcvd samples 0; on that edge rx_rcv_ack=0.
REQ-028 ACK exit: next state SHALL be WAIT with outputs re-latched per REQ-020 when cfg_en=1, otherwise IDLE.
REQ-029 Minimum rx_rcv_ack high time SHALL be 1 cycle; latency from rx_data_rcvd rising to rx_rcv_ack rising SHALL be exactly 2 RX_CLK cycles.
REQ-030 Host side: frm_valid=full[rp], frm_buf=rp, frm_len=len[rp], all combinational from registers.
REQ-031 frm_valid&frm_ready on an edge SHALL clear full[rp] and toggle rp; frm_ready while frm_valid=0 SHALL be ignored.
REQ-032 A release and a CHECK fill in the same cycle SHALL both take effect (fill at wp, release at rp).
REQ-033 Both buffers full SHALL cause every subsequent frame to be dropped via rx_wr_en=0 until a release plus re-latch occurs.
REQ-034 Counters SHALL saturate at 16'hFFFF.
REQ-035 cfg_en deasserted in WAIT/CHECK/ACK SHALL NOT abort the current frame; the return to IDLE occurs only at ACK exit; frames already in the buffers remain readable.

Reset
REQ-036 rst=1 SHALL immediately force: state IDLE, full=0, wp=rp=0, len=0, rx_rcv_ack=0, rx_nbytes=0, rx_buf_sel=0, rx_wr_en=0, drop_cnt=0, crc_err_cnt=0; therefore frm_valid=0, frm_buf=0, frm_len=0.
REQ-037 rst asserted mid-frame or mid-ACK SHALL discard all buffer state; after release, the block restarts from IDLE.

Verification
REQ-038 cfg_en=1, cfg_nbytes=64, good frame (crc=CRC_RESIDUE) -> rx_rcv_ack rises 2 cycles after rx_data_rcvd; frm_valid=1, frm_buf=0, frm_len=64; next rx_buf_sel=1.
REQ-039 Bad-CRC frame (crc=0) -> crc_err_cnt=1, frm_valid stays 0, wp unchanged, rx_rcv_ack still issued.
REQ-040 Three good frames with no host release -> frames 1 and 2 in buffers 0 and 1, rx_wr_en=0 for frame 3, drop_cnt=1; release of buffer 0 -> next frame written to buffer 0.
REQ-041 cfg_nbytes=2047 -> rx_nbytes=1500; frm_ready pulsed on the same edge as a CHECK fill -> both buffer updates applied.
REQ-042 rst asserted during ACK with one full buffer -> all outputs zero; after release, a good frame lands in buffer 0.
